// File: rtl/insfetch.sv
// insfetch: instruction fetch with static jal / bimodal branch prediction, decoder stall hold buffer and ROB redirect
module insfetch #(
  parameter int          BHT_BITS = 8,
  parameter logic [31:0] RESET_PC = 32'h0
) (
  input  logic        clk_in,
  input  logic        rst_in,
  input  logic        rdy_in,
  output logic        ic_req,
  output logic [31:0] ic_addr,
  input  logic        ic_ready,
  input  logic [31:0] ic_ins,
  input  logic        f_stall,
  output logic        is_ins,
  output logic [31:0] ins,
  output logic [31:0] ins_addr,
  output logic        pred_jmp,
  output logic [31:0] pred_another,
  input  logic        rob_clear,
  input  logic [31:0] rob_new_pc,
  input  logic        br_upd,
  input  logic [31:0] br_upd_pc,
  input  logic        br_upd_taken
);
  typedef enum logic {S_FETCH, S_HOLD} state_t;
  state_t state_q, state_d;
  logic [31:0] pc_q, pc_d, hold_q, hold_d, ins_q, ins_d, ins_addr_q, ins_addr_d, pred_another_q, pred_another_d;
  logic is_ins_q, is_ins_d, pred_jmp_q, pred_jmp_d;
  logic [1:0] bht_q [0:(1<<BHT_BITS)-1];
  logic [31:0] cur, imm_j, imm_b, tgt, seq;
  logic is_jal, is_br, pj, emit;
  logic [BHT_BITS-1:0] upd_idx;
  logic [1:0] upd_old, upd_new;
  logic unused_upd;
  assign unused_upd = ^{br_upd_pc[31:BHT_BITS+2], br_upd_pc[1:0]};
  always_ff @(posedge clk_in) begin
    if (rst_in) begin
      state_q        <= S_FETCH;
      pc_q           <= RESET_PC;
      hold_q         <= '0;
      is_ins_q       <= 1'b0;
      ins_q          <= '0;
      ins_addr_q     <= '0;
      pred_jmp_q     <= 1'b0;
      pred_another_q <= '0;
      for (int i = 0; i < (1 << BHT_BITS); i++) bht_q[i] <= 2'b01;
    end else if (rdy_in) begin
      state_q        <= state_d;
      pc_q           <= pc_d;
      hold_q         <= hold_d;
      is_ins_q       <= is_ins_d;
      ins_q          <= ins_d;
      ins_addr_q     <= ins_addr_d;
      pred_jmp_q     <= pred_jmp_d;
      pred_another_q <= pred_another_d;
      if (br_upd) bht_q[upd_idx] <= upd_new;
    end
  end
  // Prediction is evaluated on whichever word is being emitted: the buffered one in S_HOLD, else the live icache data
  always_comb begin
    cur     = (state_q == S_HOLD) ? hold_q : ic_ins;
    imm_j   = {{12{cur[31]}}, cur[19:12], cur[20], cur[30:21], 1'b0};
    imm_b   = {{20{cur[31]}}, cur[7], cur[30:25], cur[11:8], 1'b0};
    is_jal  = cur[6:0] == 7'b1101111;
    is_br   = cur[6:0] == 7'b1100011;
    pj      = is_jal || (is_br && bht_q[pc_q[BHT_BITS+1:2]][1]);
    tgt     = pc_q + (is_jal ? imm_j : imm_b);
    seq     = pc_q + 32'd4;
    emit    = !rob_clear && !f_stall && (state_q == S_HOLD || ic_ready);
    upd_idx = br_upd_pc[BHT_BITS+1:2];
    upd_old = bht_q[upd_idx];
    upd_new = br_upd_taken ? (&upd_old ? upd_old : upd_old + 2'd1) : (|upd_old ? upd_old - 2'd1 : upd_old);
    state_d        = (rob_clear || emit) ? S_FETCH : ((state_q == S_FETCH && ic_ready) ? S_HOLD : state_q);
    pc_d           = rob_clear ? rob_new_pc : (emit ? (pj ? tgt : seq) : pc_q);
    hold_d         = (state_q == S_FETCH && ic_ready) ? ic_ins : hold_q;
    is_ins_d       = emit;
    ins_d          = emit ? cur : ins_q;
    ins_addr_d     = emit ? pc_q : ins_addr_q;
    pred_jmp_d     = emit ? pj : pred_jmp_q;
    pred_another_d = emit ? (pj ? seq : (is_br ? tgt : seq)) : pred_another_q;
  end
  always_comb begin
    ic_req       = (state_q == S_FETCH) && !rob_clear;
    ic_addr      = pc_q;
    is_ins       = is_ins_q;
    ins          = ins_q;
    ins_addr     = ins_addr_q;
    pred_jmp     = pred_jmp_q;
    pred_another = pred_another_q;
  end
endmodule

// File: tb/tb_insfetch.sv
// tb_insfetch: directed plus randomized check of insfetch against a behavioural fetch/predict model
module tb_insfetch;
  logic clk_in = 0, rst_in, rdy_in, ic_req, ic_ready, f_stall, is_ins, pred_jmp, rob_clear, br_upd, br_upd_taken;
  logic [31:0] ic_addr, ic_ins, ins, ins_addr, pred_another, rob_new_pc, br_upd_pc;
  int total = 0, bad = 0;
  logic [31:0] m_pc, m_hw, m_ins, m_addr, m_an;
  logic m_hold, m_is, m_pj;
  int m_bht [256];
  logic [1:0]  dk  [logic [31:0]];
  logic [31:0] dof [logic [31:0]];

  insfetch dut (.clk_in(clk_in), .rst_in(rst_in), .rdy_in(rdy_in), .ic_req(ic_req), .ic_addr(ic_addr),
    .ic_ready(ic_ready), .ic_ins(ic_ins), .f_stall(f_stall), .is_ins(is_ins), .ins(ins), .ins_addr(ins_addr),
    .pred_jmp(pred_jmp), .pred_another(pred_another), .rob_clear(rob_clear), .rob_new_pc(rob_new_pc),
    .br_upd(br_upd), .br_upd_pc(br_upd_pc), .br_upd_taken(br_upd_taken));

  always #5 clk_in = ~clk_in;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // Program image: kind 0=addi 1=jal 2=beq 3=jalr, with the byte offset/immediate kept alongside
  function automatic void info(input logic [31:0] a, output logic [1:0] k, output logic [31:0] o);
    logic [31:0] h;
    if (dk.exists(a)) begin
      k = dk[a];
      o = dof[a];
      return;
    end
    h = (a >> 2) * 32'h9E3779B1;
    h = h ^ (h >> 15);
    k = h[1:0];
    o = (k == 2'd1) ? {{19{h[20]}}, h[20:10], 2'b00} :
        (k == 2'd2) ? {{20{h[12]}}, h[12:3], 2'b00} : {{20{h[23]}}, h[23:12]};
  endfunction

  function automatic logic [31:0] enc(input logic [1:0] k, input logic [31:0] o);
    case (k)
      2'd0:    return {o[11:0], 5'd0, 3'd0, 5'd1, 7'b0010011};
      2'd1:    return {o[20], o[10:1], o[11], o[19:12], 5'd1, 7'b1101111};
      2'd2:    return {o[12], o[10:5], 5'd2, 5'd1, 3'd0, o[4:1], o[11], 7'b1100011};
      default: return {o[11:0], 5'd1, 3'd0, 5'd0, 7'b1100111};
    endcase
  endfunction

  function automatic logic [31:0] word(input logic [31:0] a);
    logic [1:0] k;
    logic [31:0] o;
    info(a, k, o);
    return enc(k, o);
  endfunction

  task automatic mreset();
    m_pc = 0; m_hold = 0; m_hw = 0; m_is = 0; m_ins = 0; m_addr = 0; m_pj = 0; m_an = 0;
    foreach (m_bht[i]) m_bht[i] = 1;
  endtask

  task automatic mstep(input bit rdy, rd, st, cl, input logic [31:0] np, input bit up, input logic [31:0] upc, input bit tk);
    logic [1:0] k;
    logic [31:0] o;
    int idx;
    if (!rdy) return;
    m_is = 0;
    if (cl) begin
      m_pc = np;
      m_hold = 0;
    end else if ((m_hold || rd) && !st) begin
      info(m_pc, k, o);
      idx = int'((m_pc >> 2) & 32'hFF);
      m_is = 1;
      m_ins = m_hold ? m_hw : enc(k, o);
      m_addr = m_pc;
      if (k == 2'd1 || (k == 2'd2 && m_bht[idx] >= 2)) begin
        m_pj = 1; m_an = m_pc + 4; m_pc = m_pc + o;
      end else begin
        m_pj = 0; m_an = (k == 2'd2) ? m_pc + o : m_pc + 4; m_pc = m_pc + 4;
      end
      m_hold = 0;
    end else if (!m_hold && rd) begin
      m_hold = 1;
      m_hw = word(m_pc);
    end
    if (up) begin
      idx = int'((upc >> 2) & 32'hFF);
      m_bht[idx] = tk ? (m_bht[idx] == 3 ? 3 : m_bht[idx] + 1) : (m_bht[idx] == 0 ? 0 : m_bht[idx] - 1);
    end
  endtask

  task automatic cmp_out();
    chk("is_ins", {31'b0, is_ins}, {31'b0, m_is});
    chk("ins", ins, m_ins);
    chk("ins_addr", ins_addr, m_addr);
    chk("pred_jmp", {31'b0, pred_jmp}, {31'b0, m_pj});
    chk("pred_another", pred_another, m_an);
  endtask

  // Drive one cycle from the falling edge, check combinational outputs, advance model, check registered outputs
  task automatic step(input bit rdy, rd, st, cl, input logic [31:0] np, input bit up, input logic [31:0] upc, input bit tk);
    rdy_in = rdy; ic_ready = rd; f_stall = st; rob_clear = cl; rob_new_pc = np;
    br_upd = up; br_upd_pc = upc; br_upd_taken = tk;
    ic_ins = (!m_hold && rd) ? word(m_pc) : $urandom;
    #1;
    chk("ic_req", {31'b0, ic_req}, {31'b0, !m_hold && !cl});
    chk("ic_addr", ic_addr, m_pc);
    mstep(rdy, rd, st, cl, np, up, upc, tk);
    @(negedge clk_in);
    cmp_out();
  endtask

  task automatic fetch(input bit st);
    step(1, 1, st, 0, 0, 0, 0, 0);
  endtask

  task automatic redirect(input logic [31:0] a);
    step(1, 0, 0, 1, a, 0, 0, 0);
  endtask

  task automatic upd(input logic [31:0] a, input bit tk);
    step(1, 0, 0, 0, 0, 1, a, tk);
  endtask

  initial begin
    dk[32'h0] = 0;  dof[32'h0] = 1;
    dk[32'h4] = 0;  dof[32'h4] = 2;
    dk[32'h8] = 0;  dof[32'h8] = 3;
    dk[32'h10] = 0; dof[32'h10] = 5;
    dk[32'h20] = 1; dof[32'h20] = 16;
    dk[32'h40] = 2; dof[32'h40] = -8;
    rst_in = 1; rdy_in = 1; ic_ready = 0; ic_ins = 0; f_stall = 0; rob_clear = 0; rob_new_pc = 0;
    br_upd = 0; br_upd_pc = 0; br_upd_taken = 0;
    mreset();
    repeat (2) @(posedge clk_in);
    @(negedge clk_in);
    rst_in = 0;
    cmp_out();
    chk("rst_ic_addr", ic_addr, 32'h0);
    chk("rst_is_ins", {31'b0, is_ins}, 32'h0);
    // back-to-back addi stream
    for (int i = 0; i < 3; i++) begin
      fetch(0);
      chk("seq_is_ins", {31'b0, is_ins}, 32'h1);
      chk("seq_addr", ins_addr, 32'(i * 4));
      chk("seq_another", pred_another, 32'(i * 4 + 4));
    end
    // jal +16
    redirect(32'h20);
    fetch(0);
    chk("jal_pj", {31'b0, pred_jmp}, 32'h1);
    chk("jal_another", pred_another, 32'h24);
    chk("jal_next", ic_addr, 32'h30);
    // beq -8 weakly not-taken, then trained to taken (second update lands during a redirect)
    redirect(32'h40);
    fetch(0);
    chk("beq_nt_pj", {31'b0, pred_jmp}, 32'h0);
    chk("beq_nt_another", pred_another, 32'h38);
    upd(32'h40, 1);
    step(1, 0, 0, 1, 32'h40, 1, 32'h40, 1);
    fetch(0);
    chk("beq_t_pj", {31'b0, pred_jmp}, 32'h1);
    chk("beq_t_next", ic_addr, 32'h38);
    chk("beq_t_another", pred_another, 32'h44);
    // saturate high then low
    for (int i = 0; i < 5; i++) upd(32'h40, 1);
    redirect(32'h40);
    fetch(0);
    chk("sat_hi_pj", {31'b0, pred_jmp}, 32'h1);
    for (int i = 0; i < 5; i++) upd(32'h40, 0);
    upd(32'h40, 1);
    redirect(32'h40);
    fetch(0);
    chk("sat_lo_pj", {31'b0, pred_jmp}, 32'h0);
    // decoder stall with hold buffer
    redirect(32'h10);
    for (int i = 0; i < 3; i++) begin
      fetch(1);
      chk("stall_is_ins", {31'b0, is_ins}, 32'h0);
      chk("stall_req", {31'b0, ic_req}, 32'h0);
    end
    step(1, 0, 0, 0, 0, 0, 0, 0);
    chk("unstall_is_ins", {31'b0, is_ins}, 32'h1);
    chk("unstall_addr", ins_addr, 32'h10);
    chk("unstall_ins", ins, 32'h00500093);
    // rob_clear from S_FETCH and from S_HOLD
    step(1, 1, 0, 1, 32'h100, 0, 0, 0);
    chk("clr_is_ins", {31'b0, is_ins}, 32'h0);
    chk("clr_addr", ic_addr, 32'h100);
    redirect(32'h10);
    fetch(1);
    step(1, 1, 0, 1, 32'h100, 0, 0, 0);
    chk("clrh_addr", ic_addr, 32'h100);
    step(1, 0, 0, 0, 0, 0, 0, 0);
    chk("clrh_dropped", {31'b0, is_ins}, 32'h0);
    // global freeze
    redirect(32'h0);
    fetch(0);
    step(0, 1, 0, 0, 0, 0, 0, 0);
    step(0, 1, 0, 0, 0, 1, 32'h0, 1);
    chk("frz_is_ins", {31'b0, is_ins}, 32'h1);
    chk("frz_addr", ins_addr, 32'h0);
    chk("frz_pc", ic_addr, 32'h4);
    // randomized traffic
    for (int n = 0; n < 3000; n++)
      step($urandom_range(0, 9) != 0, $urandom_range(0, 9) < 7, $urandom_range(0, 9) < 3,
           $urandom_range(0, 19) == 0, 32'($urandom_range(0, 1023)) << 2,
           $urandom_range(0, 4) == 0, 32'($urandom_range(0, 1023)) << 2, $urandom_range(0, 1) == 1);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
